// File: rtl/wb_axis_adapter.sv
// Wishbone slave that feeds X words to a FIR over AXI-Stream through a small FWFT FIFO
// and captures Y words from the FIR into a single register read back over Wishbone.
module wb_axis_adapter #(
  parameter int pADDR_WIDTH = 32,
  parameter int pDATA_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [pADDR_WIDTH-1:0] wbs_adr_i,
  input  logic [pDATA_WIDTH-1:0] wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [pDATA_WIDTH-1:0] wbs_dat_o,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready,
  input  logic                   sm_tvalid,
  input  logic [pDATA_WIDTH-1:0] sm_tdata,
  input  logic                   sm_tlast,
  output logic                   sm_tready
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0] OFF_LEN    = 8'h10;
  localparam logic [7:0] OFF_X      = 8'h80;
  localparam logic [7:0] OFF_Y      = 8'h84;
  localparam logic [7:0] OFF_STATUS = 8'h88;

  logic [pDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [pDATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [9:0]             len_q, len_d, xcnt_q, xcnt_d;
  logic [pDATA_WIDTH-1:0] ybuf_q, ybuf_d;
  logic                   yfull_q, yfull_d;
  logic                   last_seen_q, last_seen_d;
  logic                   ack_q, ack_d;
  logic [pDATA_WIDTH-1:0] dat_q, dat_d;

  logic       fifo_empty, fifo_full, req, push, pop, capture;
  logic       len_wr, len_rd, x_wr, y_rd, status_rd;
  logic [7:0] offset;
  logic [2:0] cnt_sat;
  logic       unused_sel;

  assign unused_sel = ^wbs_sel_i;

  // A new access is never taken while the previous ack is on the bus.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_C);
    offset     = wbs_adr_i[7:0];
    req        = wbs_cyc_i && wbs_stb_i && !ack_q && (wbs_adr_i[31:8] == 24'h30_0000);
    len_wr     = req &&  wbs_we_i && (offset == OFF_LEN);
    len_rd     = req && !wbs_we_i && (offset == OFF_LEN);
    x_wr       = req &&  wbs_we_i && (offset == OFF_X) && !fifo_full;
    y_rd       = req && !wbs_we_i && (offset == OFF_Y) && yfull_q;
    status_rd  = req && !wbs_we_i && (offset == OFF_STATUS);
    push       = x_wr;
    pop        = !fifo_empty && ss_tready;
    capture    = sm_tvalid && !yfull_q;
    if (32'(count_q) > 32'd7) cnt_sat = 3'd7;
    else                      cnt_sat = 3'(count_q);
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    len_d       = len_q;
    xcnt_d      = xcnt_q;
    ybuf_d      = ybuf_q;
    yfull_d     = yfull_q;
    last_seen_d = last_seen_q;
    ack_d       = len_wr || len_rd || x_wr || y_rd || status_rd;
    dat_d       = '0;

    if (len_rd)    dat_d[9:0] = len_q;
    if (y_rd)      dat_d      = ybuf_q;
    if (status_rd) dat_d[6:0] = {cnt_sat, last_seen_q, yfull_q, fifo_full, fifo_empty};

    if (push) begin
      mem_d[wr_ptr_q] = wbs_dat_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (xcnt_q != len_q) xcnt_d = xcnt_q + 10'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // capture and Y-read never coincide: capture needs yfull low, the read needs it high
    if (capture) begin
      ybuf_d  = sm_tdata;
      yfull_d = 1'b1;
      if (sm_tlast) last_seen_d = 1'b1;
    end
    if (y_rd) yfull_d = 1'b0;

    if (len_wr) begin
      len_d       = wbs_dat_i[9:0];
      xcnt_d      = '0;
      last_seen_d = 1'b0;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      len_q       <= '0;
      xcnt_q      <= '0;
      ybuf_q      <= '0;
      yfull_q     <= 1'b0;
      last_seen_q <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      len_q       <= len_d;
      xcnt_q      <= xcnt_d;
      ybuf_q      <= ybuf_d;
      yfull_q     <= yfull_d;
      last_seen_q <= last_seen_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign ss_tvalid = !fifo_empty;
  assign ss_tdata  = mem_q[rd_ptr_q];
  assign ss_tlast  = !fifo_empty && (len_q != 10'd0) && (xcnt_q == len_q - 10'd1);
  assign sm_tready = !yfull_q;
endmodule

// File: doc/wb_axis_adapter.md
WB_AXIS_ADAPTER -- requirements
Module: wb_axis_adapter

Interface
REQ-001 The block SHALL have the parameter pADDR_WIDTH, default 32, giving the Wishbone address width.
REQ-002 The block SHALL have the parameter pDATA_WIDTH, default 32, giving the Wishbone and stream data width.
REQ-003 The block SHALL have the parameter FIFO_DEPTH, default 4 (power of 2, at least 2), giving the number of X entries buffered toward the FIR.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset: axis_clk, in, 1, rising-edge clock; axis_rst_n, in, 1, asynchronous active-low reset.
REQ-005 The block SHALL have these Wishbone ports: wbs_cyc_i, in, 1, bus cycle; wbs_stb_i, in, 1, strobe; wbs_we_i, in, 1, write enable; wbs_sel_i, in, 4, byte select (ignored; every access is full-word).
REQ-006 The block SHALL have these Wishbone ports: wbs_adr_i, in, pADDR_WIDTH, byte address; wbs_dat_i, in, pDATA_WIDTH, write data; wbs_ack_o, out, 1, acknowledge; wbs_dat_o, out, pDATA_WIDTH, read data.
REQ-007 The block SHALL have these X stream ports toward the FIR: ss_tvalid, out, 1; ss_tdata, out, pDATA_WIDTH; ss_tlast, out, 1; ss_tready, in, 1.
REQ-008 The block SHALL have these Y stream ports from the FIR: sm_tvalid, in, 1; sm_tdata, in, pDATA_WIDTH; sm_tlast, in, 1; sm_tready, out, 1.

Function
REQ-009 An access SHALL be decoded only when wbs_cyc_i, wbs_stb_i, and wbs_adr_i[31:8] == 24'h3000_00 are all true. The decoded offsets are:
- 0x10 LEN (R/W)
- 0x80 X (W)
- 0x84 Y (R)
- 0x88 STATUS (R)
Any other offset SHALL never be acked.
REQ-010 wbs_ack_o SHALL be a registered one-cycle pulse. No new access SHALL be accepted in the cycle that wbs_ack_o is high.
REQ-011 LEN write: the block SHALL store wbs_dat_i[9:0] into len, clear xcnt and last_seen, and ack on the next cycle. LEN read SHALL return {22'b0, len}.
REQ-012 X write when the FIFO is not full: the block SHALL push wbs_dat_i and ack on the next cycle.
REQ-013 X write when the FIFO is full: the block SHALL hold the access without ack until a slot frees, then push and ack on the cycle after that.
REQ-014 Fullness for a push SHALL be evaluated before any same-cycle pop. A push therefore waits one cycle even when a pop occurs in the same cycle.
REQ-015 ss_tvalid SHALL equal !fifo_empty, and ss_tdata SHALL be the FIFO head (first-word fall-through). A pop SHALL occur on ss_tvalid && ss_tready.
REQ-016 ss_tvalid and ss_tdata SHALL hold stable while ss_tready is low.
REQ-017 xcnt (10 bits) SHALL increment on each pop.
REQ-018 ss_tlast SHALL be 1 when ss_tvalid && len != 0 && xcnt == len-1.
REQ-019 After the last pop, xcnt SHALL hold at len, and further X items SHALL be sent with ss_tlast=0.
REQ-020 The Y capture register ybuf with flag yfull SHALL drive sm_tready = !yfull.
REQ-021 On sm_tvalid && sm_tready, the block SHALL load sm_tdata into ybuf and set yfull. If sm_tlast is also 1, the block SHALL set last_seen.
REQ-022 Y read when yfull=1: the block SHALL ack on the next cycle with wbs_dat_o = ybuf and clear yfull in the same edge.
REQ-023 Y read when yfull=0: the block SHALL hold the access without ack until yfull is set, then ack on the following cycle.
REQ-024 When a Y read clears yfull, a capture SHALL NOT occur in the same cycle, because sm_tready was low that cycle.
REQ-025 STATUS read SHALL ack on the next cycle and return:
- bit0 fifo_empty
- bit1 fifo_full
- bit2 yfull
- bit3 last_seen
- bits[6:4] fifo count, saturating at 7
- all other bits 0
REQ-026 wbs_dat_o SHALL be 0 whenever wbs_ack_o is 0 or the acked access is a write.
REQ-027 The FIFO pointers SHALL wrap modulo FIFO_DEPTH. Count SHALL range 0..FIFO_DEPTH. A same-cycle push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged.

Reset
REQ-028 While axis_rst_n is low, all outputs SHALL be 0 except sm_tready, which SHALL be 1.
REQ-029 Reset SHALL clear len, xcnt, the FIFO, ybuf, yfull, last_seen, and the ack state.
REQ-030 Reset asserted mid-operation SHALL discard any pending Wishbone access (no ack) and all buffered X and Y data.

Verification
REQ-031 LEN=3; X writes 5, 6, 7 with ss_tready=1 -> three acks, each 1 cycle after stb; ss_tdata sequence 5, 6, 7; ss_tlast=1 only with 7.
REQ-032 ss_tready=0; 5 X writes with FIFO_DEPTH=4 -> first 4 acked and STATUS reads 0x42; the 5th write is acked 2 cycles after ss_tready rises for one cycle.
REQ-033 Y read issued with no Y data -> no ack; sm_tvalid=1 with sm_tdata=0x1234 and sm_tlast=1 -> ack 2 cycles later with 0x1234; STATUS bit3=1.
REQ-034 Y held unread while the FIR offers another Y -> sm_tready=0 and the second value is not captured until the first is read.
REQ-035 Reset pulse with 2 X items queued and a stalled Y read -> no ack, ss_tvalid=0, STATUS reads 0x01.
REQ-036 Access to offset 0x00 -> never acked; LEN write 0 -> ss_tlast stays 0 for all items.
